// File: rtl/mini_vga_rx.sv
// VGA-style stream receiver: frame/line recovery, active-area measurement, lock, decimated capture.
// Optional MINI_VGA_RX_DECIMATE_V_EN: vertical decimation by the same factor as scale_h.
module mini_vga_rx #(
  parameter int LINE_BITS = 10,
  parameter int BPP       = 3,
  parameter int ADDR_BITS = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LINE_BITS-1:0] scale_h,
  input  logic                 vga_hs,
  input  logic                 vga_vs,
  input  logic                 vga_de,
  input  logic [BPP-1:0]       vga_color,
  output logic                 locked,
  output logic                 frame_start,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [BPP-1:0]       wr_data,
  output logic [LINE_BITS-1:0] active_width,
  output logic [LINE_BITS-1:0] active_height,
  output logic                 sync_error
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [LINE_BITS-1:0] ONE_L = {{(LINE_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ONE_A = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  // Lines are delimited by de alone; hsync carries no extra information here.
  logic hs_unused;
  assign hs_unused = vga_hs;

  logic                 vs_q, vs_p_q, de_q, de_p_q;
  logic [BPP-1:0]       color_q;
  state_e               state_q, state_d;
  logic [LINE_BITS-1:0] w_cnt_q, w_cnt_d, h_cnt_q, h_cnt_d;
  logic [LINE_BITS-1:0] cand_w_q, cand_w_d;
  logic                 cand_v_q, cand_v_d, mm_q, mm_d;
  logic [LINE_BITS-1:0] dec_cnt_q, dec_cnt_d, dec_rld_q, dec_rld_d;
  logic [ADDR_BITS-1:0] addr_ptr_q, addr_ptr_d;
  logic                 locked_q, locked_d, fs_q, fs_d, se_q, se_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [BPP-1:0]       wr_data_q, wr_data_d;
  logic [LINE_BITS-1:0] aw_q, aw_d, ah_q, ah_d;
`ifdef MINI_VGA_RX_DECIMATE_V_EN
  logic [LINE_BITS-1:0] vcnt_q, vcnt_d, vcnt_base;
  logic                 line_wr_q, line_wr_d;
`endif

  logic                 frame_edge, line_start, line_end;
  logic [LINE_BITS-1:0] h_eff, cand_eff, smax_m1;
  logic                 mm_eff, cand_v_eff, wr_go, line_ok, capture;
  logic [ADDR_BITS-1:0] addr_base;

  assign frame_edge = vs_p_q & ~vs_q;
  assign line_start = de_q & ~de_p_q;
  assign line_end   = de_p_q & ~de_q;
  assign smax_m1    = (scale_h == '0) ? '0 : scale_h - ONE_L;

  // Measurement and lock; a line end in the frame-edge cycle is folded in first.
  always_comb begin
    w_cnt_d = w_cnt_q;
    if (line_start)                 w_cnt_d = ONE_L;
    else if (de_q && w_cnt_q != '1) w_cnt_d = w_cnt_q + ONE_L;

    h_eff      = h_cnt_q;
    mm_eff     = mm_q;
    cand_eff   = cand_w_q;
    cand_v_eff = cand_v_q;
    if (line_end) begin
      if (h_cnt_q != '1) h_eff = h_cnt_q + ONE_L;
      if (state_q == MEASURE) begin
        if (!cand_v_q) begin
          cand_eff   = w_cnt_q;
          cand_v_eff = 1'b1;
        end else if (w_cnt_q != cand_w_q) begin
          mm_eff = 1'b1;
        end
      end else if (w_cnt_q != aw_q) begin
        mm_eff = 1'b1;
      end
    end

    state_d  = state_q;
    h_cnt_d  = h_eff;
    mm_d     = mm_eff;
    cand_w_d = cand_eff;
    cand_v_d = cand_v_eff;
    locked_d = locked_q;
    fs_d     = 1'b0;
    se_d     = 1'b0;
    aw_d     = aw_q;
    ah_d     = ah_q;

    case (state_q)
      SEARCH: begin
        h_cnt_d  = '0;
        mm_d     = 1'b0;
        cand_v_d = 1'b0;
        if (frame_edge) state_d = MEASURE;
      end
      MEASURE: if (frame_edge) begin
        h_cnt_d  = '0;
        mm_d     = 1'b0;
        cand_v_d = 1'b0;
        if (h_eff != '0 && !mm_eff) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
          aw_d     = cand_eff;
          ah_d     = h_eff;
        end
      end
      LOCKED: if (frame_edge) begin
        h_cnt_d  = '0;
        mm_d     = 1'b0;
        cand_v_d = 1'b0;
        if (mm_eff || h_eff != ah_q) begin
          se_d     = 1'b1;
          locked_d = 1'b0;
          state_d  = MEASURE;
        end else begin
          fs_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Capture: first pixel of each line always taken, then every max(scale_h,1)-th.
  always_comb begin
    wr_go     = 1'b0;
    dec_cnt_d = dec_cnt_q;
    dec_rld_d = dec_rld_q;
    if (line_start) begin
      wr_go     = 1'b1;
      dec_cnt_d = smax_m1;
      dec_rld_d = smax_m1;
    end else if (de_q) begin
      if (dec_cnt_q == '0) begin
        wr_go     = 1'b1;
        dec_cnt_d = dec_rld_q;
      end else begin
        dec_cnt_d = dec_cnt_q - ONE_L;
      end
    end

`ifdef MINI_VGA_RX_DECIMATE_V_EN
    vcnt_base = frame_edge ? '0 : vcnt_q;
    vcnt_d    = vcnt_base;
    line_wr_d = line_wr_q;
    if (line_start) begin
      line_wr_d = (vcnt_base == '0);
      vcnt_d    = (vcnt_base == '0) ? smax_m1 : vcnt_base - ONE_L;
    end
    line_ok = line_start ? (vcnt_base == '0) : line_wr_q;
`else
    line_ok = 1'b1;
`endif

    capture    = (state_q == LOCKED) && wr_go && line_ok;
    addr_base  = frame_edge ? '0 : addr_ptr_q;
    addr_ptr_d = capture ? addr_base + ONE_A : addr_base;
    wr_en_d    = capture;
    wr_addr_d  = capture ? addr_base : (frame_edge ? '0 : wr_addr_q);
    wr_data_d  = capture ? color_q : wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q       <= 1'b0;
      vs_p_q     <= 1'b0;
      de_q       <= 1'b0;
      de_p_q     <= 1'b0;
      color_q    <= '0;
      state_q    <= SEARCH;
      w_cnt_q    <= '0;
      h_cnt_q    <= '0;
      cand_w_q   <= '0;
      cand_v_q   <= 1'b0;
      mm_q       <= 1'b0;
      dec_cnt_q  <= '0;
      dec_rld_q  <= '0;
      addr_ptr_q <= '0;
      locked_q   <= 1'b0;
      fs_q       <= 1'b0;
      se_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      aw_q       <= '0;
      ah_q       <= '0;
`ifdef MINI_VGA_RX_DECIMATE_V_EN
      vcnt_q     <= '0;
      line_wr_q  <= 1'b0;
`endif
    end else begin
      vs_q       <= vga_vs;
      vs_p_q     <= vs_q;
      de_q       <= vga_de;
      de_p_q     <= de_q;
      color_q    <= vga_color;
      state_q    <= state_d;
      w_cnt_q    <= w_cnt_d;
      h_cnt_q    <= h_cnt_d;
      cand_w_q   <= cand_w_d;
      cand_v_q   <= cand_v_d;
      mm_q       <= mm_d;
      dec_cnt_q  <= dec_cnt_d;
      dec_rld_q  <= dec_rld_d;
      addr_ptr_q <= addr_ptr_d;
      locked_q   <= locked_d;
      fs_q       <= fs_d;
      se_q       <= se_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      aw_q       <= aw_d;
      ah_q       <= ah_d;
`ifdef MINI_VGA_RX_DECIMATE_V_EN
      vcnt_q     <= vcnt_d;
      line_wr_q  <= line_wr_d;
`endif
    end
  end

  assign locked        = locked_q;
  assign frame_start   = fs_q;
  assign sync_error    = se_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign active_width  = aw_q;
  assign active_height = ah_q;

endmodule

// File: tb/tb_mini_vga_rx.sv
// Scoreboard bench for mini_vga_rx: writes queued at stimulus time, matched as wr_en appears.
module tb_mini_vga_rx;
  localparam int LB = 10, BPP = 3, AB = 17, RST_PX = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [LB-1:0] scale_h;
  logic          vga_hs, vga_vs, vga_de;
  logic [BPP-1:0] vga_color;
  logic          locked, frame_start, wr_en, sync_error;
  logic [AB-1:0] wr_addr;
  logic [BPP-1:0] wr_data;
  logic [LB-1:0] active_width, active_height;

  mini_vga_rx #(.LINE_BITS(LB), .BPP(BPP), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .scale_h(scale_h),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_color(vga_color),
    .locked(locked), .frame_start(frame_start), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .active_width(active_width), .active_height(active_height),
    .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; int data; } exp_t;
  exp_t sb[$];

  int  cyc = 0;
  int  n_vec = 0, n_err = 0;
  int  fe_chk_cyc = -1, rst_chk_cyc = -1;
  bit  fe_lk, fe_fs, fe_se, lk_exp = 1'b0, mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    bit   ew;
    exp_t e;
    if (mon_en) begin
      if (cyc == rst_chk_cyc) begin
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fs",     32'(frame_start), 0);
        chk("rst_se",     32'(sync_error), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_act_w",  32'(active_width), 0);
        chk("rst_act_h",  32'(active_height), 0);
        lk_exp = 1'b0;
      end else if (cyc == fe_chk_cyc) begin
        chk("fe_locked",   32'(locked), 32'(fe_lk));
        chk("frame_start", 32'(frame_start), 32'(fe_fs));
        chk("sync_error",  32'(sync_error), 32'(fe_se));
        lk_exp = fe_lk;
      end else begin
        chk("pulse_idle", 32'({frame_start, sync_error}), 0);
        chk("locked", 32'(locked), 32'(lk_exp));
      end
      ew = (sb.size() > 0) && (sb[0].cyc == cyc);
      chk("wr_en", 32'(wr_en), 32'(ew));
      if (ew) begin
        e = sb.pop_front();
        if (wr_en) begin
          chk("wr_addr", 32'(wr_addr), e.addr);
          chk("wr_data", 32'(wr_data), e.data);
        end
      end
    end
  end

  task automatic step(input logic vs, input logic hs, input logic de,
                      input logic [BPP-1:0] col, input logic rst);
    vga_vs = vs; vga_hs = hs; vga_de = de; vga_color = col; reset = rst;
    @(posedge clk); #1;
  endtask

  function automatic bit vline_ok(input int l, input int s);
`ifdef MINI_VGA_RX_DECIMATE_V_EN
    return (l % s) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // One frame: vsync, blank, h lines of w pixels; optional short line / mid-line reset.
  task automatic send_frame(input int w, input int h, input int sc, input bit wr,
                            input int short_l, input int rst_l,
                            input bit e_lk, input bit e_fs, input bit e_se);
    int addr, s, pw;
    bit on, r;
    logic [BPP-1:0] c;
    scale_h = LB'(sc);
    s    = (sc == 0) ? 1 : sc;
    addr = 0;
    on   = wr;
    fe_chk_cyc = cyc + 2; fe_lk = e_lk; fe_fs = e_fs; fe_se = e_se;
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int l = 0; l < h; l++) begin
      pw = (l == short_l) ? w - 1 : w;
      for (int x = 0; x < pw; x++) begin
        c = BPP'($urandom_range(0, 7));
        if (l == rst_l && x == RST_PX - 1) on = 1'b0;
        if (on && (x % s) == 0 && vline_ok(l, s)) begin
          sb.push_back('{cyc: cyc + 2, addr: addr, data: int'(c)});
          addr++;
        end
        r = (l == rst_l && x == RST_PX);
        if (r) rst_chk_cyc = cyc + 1;
        step(1'b1, 1'b1, 1'b1, c, r);
      end
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    end
    repeat (4) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    scale_h = LB'(1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    rst_chk_cyc = cyc + 1;
    step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Acquire lock, then capture at full rate.
    send_frame(16, 4, 1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    send_frame(16, 4, 1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    send_frame(16, 4, 1, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("active_width",  32'(active_width), 16);
    chk("active_height", 32'(active_height), 4);

    // Decimation factors 4, 0 (treated as 1) and 2.
    send_frame(16, 4, 4, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0);
    send_frame(16, 4, 0, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0);
    send_frame(16, 4, 2, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0);

    // Short line -> loss of lock at the next edge, then relock.
    send_frame(16, 4, 1, 1'b1, 1, -1, 1'b1, 1'b1, 1'b0);
    send_frame(16, 4, 1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b1);
    send_frame(16, 4, 1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    chk("relock_width",  32'(active_width), 16);

    // Mid-line reset while locked; lock must be re-acquired from scratch.
    send_frame(16, 4, 1, 1'b1, -1, 2, 1'b1, 1'b1, 1'b0);
    send_frame(16, 4, 1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    send_frame(16, 4, 1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
    send_frame(16, 4, 1, 1'b1, -1, -1, 1'b1, 1'b1, 1'b0);
    chk("final_height", 32'(active_height), 4);

    repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
